// File: rtl/vga_scanout.sv
// vga_scanout: VGA raster timing generator and pixel unpacker at the read end of
// the 128-bit frame-data FIFO. Each FIFO word carries four 24-bit pixels in
// 32-bit lanes. A fetch with no data shows UNDERFLOW_RGB for the whole group
// and sets a sticky underflow flag.
// Build option: define VGA_SCANOUT_TEST_PATTERN_EN to add the test_pattern_sel
// input and an 8-bar colour pattern generator.
module vga_scanout #(
    parameter int          IMAGE_WIDTH   = 1280,
    parameter int          IMAGE_HEIGHT  = 1024,
    parameter int          H_FRONT       = 48,
    parameter int          H_SYNC        = 112,
    parameter int          H_BACK        = 248,
    parameter int          V_FRONT       = 1,
    parameter int          V_SYNC        = 3,
    parameter int          V_BACK        = 38,
    parameter logic [23:0] UNDERFLOW_RGB = 24'hFF00FF
) (
    input  logic         vga_clk,
    input  logic         vga_reset_n,
    input  logic         scan_enable,
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    input  logic         test_pattern_sel,
`endif
    input  logic         data_fifo_empty,
    input  logic [127:0] data_fifo_rd_data,
    input  logic         clear_underflow,
    output logic         vga_rd_valid,
    output logic         vga_hs,
    output logic         vga_vs,
    output logic         vga_blank_n,
    output logic [7:0]   vga_r,
    output logic [7:0]   vga_g,
    output logic [7:0]   vga_b,
    output logic         frame_start,
    output logic         underflow
);
    localparam int H_TOTAL = IMAGE_WIDTH + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = IMAGE_HEIGHT + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(IMAGE_WIDTH);
    localparam logic [HW-1:0] HS_BEG = HW'(IMAGE_WIDTH + H_FRONT);
    localparam logic [HW-1:0] HS_END = HW'(IMAGE_WIDTH + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(IMAGE_HEIGHT);
    localparam logic [VW-1:0] VS_BEG = VW'(IMAGE_HEIGHT + V_FRONT);
    localparam logic [VW-1:0] VS_END = VW'(IMAGE_HEIGHT + V_FRONT + V_SYNC);

    logic [HW-1:0]  h_cnt_q, h_cnt_d;
    logic [VW-1:0]  v_cnt_q, v_cnt_d;
    logic           frame_active_q, frame_active_d;
    logic [127:0]   hold_q, hold_d;
    logic           grp_valid_q, grp_valid_d;
    logic           underflow_q, underflow_d;
    logic           hs_q, hs_d;
    logic           vs_q, vs_d;
    logic           blank_n_q, blank_n_d;
    logic           frame_start_q, frame_start_d;
    logic [23:0]    rgb_q, rgb_d;

    logic           frame_top, active, frame_en, pattern_on;
    logic           fetch_slot, pop, miss;
    logic [1:0]     pix_idx;
    logic [23:0]    bar_rgb;

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    logic           pattern_q, pattern_d;
    logic [31:0]    bar_prod;
    logic [2:0]     bar_idx;
    logic           unused_bar;

    // Colour-bar generator: bar index bits map to R, G and B full-scale
    always_comb begin
        bar_prod = (32'(h_cnt_q) * 32'd8) / 32'(IMAGE_WIDTH);
        bar_idx  = bar_prod[2:0];
        bar_rgb  = {{8{bar_idx[2]}}, {8{bar_idx[1]}}, {8{bar_idx[0]}}};
    end
    assign unused_bar = ^bar_prod[31:3];
`else
    assign bar_rgb = '0;
`endif

    // Region decode, frame gating and fetch decision for the current counter state
    always_comb begin
        frame_top  = (h_cnt_q == '0) && (v_cnt_q == '0);
        active     = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        // The frame-start cycle already uses the freshly sampled enable so the
        // first pixel of the frame can be fetched.
        frame_en   = frame_top ? scan_enable : frame_active_q;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        pattern_on = frame_top ? test_pattern_sel : pattern_q;
`else
        pattern_on = 1'b0;
`endif
        pix_idx    = h_cnt_q[1:0];
        fetch_slot = active && frame_en && !pattern_on && (pix_idx == 2'd0);
        pop        = fetch_slot && !data_fifo_empty;
        miss       = fetch_slot && data_fifo_empty;
    end

    // Pop is combinational so the show-ahead head word is consumed in its fetch
    // cycle; reset masks it because the frame-start decode is live during reset.
    assign vga_rd_valid = pop && vga_reset_n;

    // Next state for counters, frame gating, holding register and underflow
    always_comb begin
        h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
        end
        frame_active_d = frame_en;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        pattern_d      = pattern_on;
`endif
        hold_d         = pop ? data_fifo_rd_data : hold_q;
        grp_valid_d    = fetch_slot ? !data_fifo_empty : grp_valid_q;
        underflow_d    = miss ? 1'b1 : (clear_underflow ? 1'b0 : underflow_q);
    end

    // Registered video outputs, all derived from the same counter state
    always_comb begin
        hs_d          = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
        vs_d          = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
        blank_n_d     = active;
        frame_start_d = frame_top;
        rgb_d         = '0;
        if (active && frame_en) begin
            if (pattern_on) begin
                rgb_d = bar_rgb;
            end else if (pix_idx == 2'd0) begin
                // Pixel 0 of a group comes straight from the FIFO head word.
                rgb_d = data_fifo_empty ? UNDERFLOW_RGB : data_fifo_rd_data[23:0];
            end else begin
                rgb_d = grp_valid_q ? hold_q[{pix_idx, 5'd0} +: 24] : UNDERFLOW_RGB;
            end
        end
    end

    // State and output registers
    always_ff @(posedge vga_clk or negedge vga_reset_n) begin
        if (!vga_reset_n) begin
            h_cnt_q        <= '0;
            v_cnt_q        <= '0;
            frame_active_q <= 1'b0;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
            pattern_q      <= 1'b0;
`endif
            hold_q         <= '0;
            grp_valid_q    <= 1'b0;
            underflow_q    <= 1'b0;
            hs_q           <= 1'b0;
            vs_q           <= 1'b0;
            blank_n_q      <= 1'b0;
            frame_start_q  <= 1'b0;
            rgb_q          <= '0;
        end else begin
            h_cnt_q        <= h_cnt_d;
            v_cnt_q        <= v_cnt_d;
            frame_active_q <= frame_active_d;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
            pattern_q      <= pattern_d;
`endif
            hold_q         <= hold_d;
            grp_valid_q    <= grp_valid_d;
            underflow_q    <= underflow_d;
            hs_q           <= hs_d;
            vs_q           <= vs_d;
            blank_n_q      <= blank_n_d;
            frame_start_q  <= frame_start_d;
            rgb_q          <= rgb_d;
        end
    end

    // Lane 0 and the pad byte of each lane are never displayed from the holding register.
    logic unused_hold;
    assign unused_hold = ^{hold_q[31:0], hold_q[63:56], hold_q[95:88], hold_q[127:120]};

    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank_n = blank_n_q;
    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a reduced raster (64x4 active, 88x9 total).
module tb_vga_scanout;
    localparam int IW = 64;
    localparam int IH = 4;
    localparam int HF = 4;
    localparam int HS = 8;
    localparam int HB = 12;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int HT = 88;   // 64+4+8+12
    localparam int VT = 9;    // 4+1+2+2
    localparam int FT = 792;  // 88*9

    logic         vga_clk;
    logic         vga_reset_n;
    logic         scan_enable;
    logic         data_fifo_empty;
    logic [127:0] data_fifo_rd_data;
    logic         clear_underflow;
    logic         vga_rd_valid;
    logic         vga_hs, vga_vs, vga_blank_n;
    logic [7:0]   vga_r, vga_g, vga_b;
    logic         frame_start;
    logic         underflow;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    logic         test_pattern_sel;
`endif

    int errors = 0;
    int checks = 0;

    // FIFO model: show-ahead head word, popped on vga_rd_valid
    logic [127:0] mem [0:127];
    int           wr_cnt = 0;
    int           rd_ptr = 0;
    logic         force_empty;
    int           cyc;

    assign data_fifo_empty   = force_empty || (rd_ptr >= wr_cnt);
    assign data_fifo_rd_data = mem[rd_ptr[6:0]];

    always @(posedge vga_clk) if (vga_rd_valid) rd_ptr <= rd_ptr + 1;

    // Cycles since reset release equals the raster position h + HT*v (mod frame)
    always @(posedge vga_clk or negedge vga_reset_n) begin
        if (!vga_reset_n) cyc <= 0;
        else              cyc <= cyc + 1;
    end

    vga_scanout #(
        .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH),
        .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .UNDERFLOW_RGB(24'hFF00FF)
    ) dut (
        .vga_clk(vga_clk),
        .vga_reset_n(vga_reset_n),
        .scan_enable(scan_enable),
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        .test_pattern_sel(test_pattern_sel),
`endif
        .data_fifo_empty(data_fifo_empty),
        .data_fifo_rd_data(data_fifo_rd_data),
        .clear_underflow(clear_underflow),
        .vga_rd_valid(vga_rd_valid),
        .vga_hs(vga_hs),
        .vga_vs(vga_vs),
        .vga_blank_n(vga_blank_n),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b),
        .frame_start(frame_start),
        .underflow(underflow)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] grey_word(input int n);
        logic [7:0] b;
        b = 8'(n);
        return {4{8'h00, b, b, b}};
    endfunction

    // Waits until the DUT counters (current state, not outputs) reach (h, v).
    task automatic wait_cnt(input int h, input int v, output bit to);
        int n;
        n = 0;
        do begin
            @(negedge vga_clk);
            n++;
        end while (!(((cyc % HT) == h) && (((cyc / HT) % VT) == v)) && n < 2 * FT);
        to = !(((cyc % HT) == h) && (((cyc / HT) % VT) == v));
    endtask

    task automatic test_reset();
        bit to;
        int w, c0;
        vga_reset_n = 1'b0;
        repeat (3) @(negedge vga_clk);
        checks++;
        if ({vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, frame_start, underflow, vga_rd_valid} !== 30'd0)
            begin errors++; $display("FAIL reset_outputs: got %h want 0",
                {vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, frame_start, underflow, vga_rd_valid}); end
        vga_reset_n = 1'b1;
        wait_cnt(40, 0, to);
        checks++;
        if (to || vga_blank_n !== 1'b1) begin errors++; $display("FAIL pre_reset_blank: got %b want 1", vga_blank_n); end
        vga_reset_n = 1'b0;
        #1;
        checks++;
        if ({vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, frame_start, underflow, vga_rd_valid} !== 30'd0)
            begin errors++; $display("FAIL midline_reset: got %h want 0",
                {vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, frame_start, underflow, vga_rd_valid}); end
        @(negedge vga_clk);
        @(negedge vga_clk);
        vga_reset_n = 1'b1;
        @(negedge vga_clk);
        checks++;
        if (frame_start !== 1'b1 || vga_blank_n !== 1'b1 || {vga_r, vga_g, vga_b} !== 24'h0)
            begin errors++; $display("FAIL first_frame_start: fs=%b blank_n=%b rgb=%h want 1 1 0",
                frame_start, vga_blank_n, {vga_r, vga_g, vga_b}); end
        @(negedge vga_clk);
        checks++;
        if (frame_start !== 1'b0) begin errors++; $display("FAIL frame_start_width: got %b want 0", frame_start); end
        w = 0;
        while (!vga_hs && w < 2 * FT) begin @(negedge vga_clk); w++; end
        checks++;
        if (cyc !== 69) begin errors++; $display("FAIL hs_first_rise: got cycle %0d want 69", cyc); end
        c0 = cyc; w = 0;
        while (vga_hs && w < 2 * FT) begin @(negedge vga_clk); w++; end
        checks++;
        if (cyc - c0 !== 8) begin errors++; $display("FAIL hs_width: got %0d want 8", cyc - c0); end
        w = 0;
        while (!vga_hs && w < 2 * FT) begin @(negedge vga_clk); w++; end
        checks++;
        if (cyc - c0 !== 88) begin errors++; $display("FAIL line_period: got %0d want 88", cyc - c0); end
        w = 0;
        while (!vga_vs && w < 2 * FT) begin @(negedge vga_clk); w++; end
        checks++;
        if (cyc !== 441) begin errors++; $display("FAIL vs_rise: got cycle %0d want 441", cyc); end
        c0 = cyc; w = 0;
        while (vga_vs && w < 2 * FT) begin @(negedge vga_clk); w++; end
        checks++;
        if (cyc - c0 !== 176) begin errors++; $display("FAIL vs_width: got %0d want 176", cyc - c0); end
        w = 0;
        while (!frame_start && w < 2 * FT) begin @(negedge vga_clk); w++; end
        checks++;
        if (cyc !== 793) begin errors++; $display("FAIL frame_period: got cycle %0d want 793", cyc); end
    endtask

    task automatic test_line_fetch();
        bit to;
        int p0, n;
        logic exp_pop;
        logic [23:0] exp_rgb;
        wait_cnt(1, 0, to);
        for (int k = 0; k < 16; k++) begin mem[wr_cnt] = grey_word(k); wr_cnt++; end
        p0 = rd_ptr;
        scan_enable = 1'b1;
        wait_cnt(0, 0, to);
        checks++;
        if (to) begin errors++; $display("FAIL line_wait: frame start not reached"); end
        for (int i = 0; i <= IW; i++) begin
            if (i > 0) @(negedge vga_clk);
            if (i == 1) scan_enable = 1'b0;
            exp_pop = (i < IW) && (i % 4 == 0);
            checks++;
            if (vga_rd_valid !== exp_pop)
                begin errors++; $display("FAIL line_pop h=%0d: got %b want %b", i, vga_rd_valid, exp_pop); end
            if (i > 0) begin
                n = (i - 1) / 4;
                exp_rgb = {8'(n), 8'(n), 8'(n)};
                checks++;
                if ({vga_r, vga_g, vga_b} !== exp_rgb || vga_blank_n !== 1'b1)
                    begin errors++; $display("FAIL line_pixel %0d: got %h blank_n=%b want %h 1",
                        i - 1, {vga_r, vga_g, vga_b}, vga_blank_n, exp_rgb); end
            end
        end
        checks++;
        if (underflow !== 1'b0) begin errors++; $display("FAIL line_underflow: got %b want 0", underflow); end
        checks++;
        if (rd_ptr - p0 !== 16) begin errors++; $display("FAIL line_pop_count: got %0d want 16", rd_ptr - p0); end
    endtask

    task automatic test_unpack_underflow();
        bit to;
        logic [23:0] exp4 [4];
        logic [23:0] exp_rgb;
        exp4[0] = 24'hFFEEDD; exp4[1] = 24'h665544; exp4[2] = 24'hCCBBAA; exp4[3] = 24'h332211;
        wait_cnt(1, 0, to);
        mem[wr_cnt] = 128'h00332211_00CCBBAA_00665544_00FFEEDD; wr_cnt++;
        for (int k = 1; k < 16; k++) begin mem[wr_cnt] = grey_word(k); wr_cnt++; end
        scan_enable = 1'b1;
        wait_cnt(0, 0, to);
        checks++;
        if (to || vga_rd_valid !== 1'b1) begin errors++; $display("FAIL unpack_first_pop: got %b want 1", vga_rd_valid); end
        for (int i = 1; i <= 4; i++) begin
            @(negedge vga_clk);
            if (i == 1) scan_enable = 1'b0;
            checks++;
            if ({vga_r, vga_g, vga_b} !== exp4[i-1])
                begin errors++; $display("FAIL unpack_pixel %0d: got %h want %h", i - 1, {vga_r, vga_g, vga_b}, exp4[i-1]); end
        end
        wait_cnt(20, 0, to);
        checks++;
        if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky: got %b want 1", underflow); end
        clear_underflow = 1'b1;
        @(negedge vga_clk);
        clear_underflow = 1'b0;
        checks++;
        if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear: got %b want 0", underflow); end
        wait_cnt(40, 0, to);
        checks++;
        if ({vga_r, vga_g, vga_b} !== 24'h090909)
            begin errors++; $display("FAIL pixel_39: got %h want 090909", {vga_r, vga_g, vga_b}); end
        force_empty = 1'b1;
        clear_underflow = 1'b1;
        #1;
        checks++;
        if (vga_rd_valid !== 1'b0) begin errors++; $display("FAIL miss_no_pop: got %b want 0", vga_rd_valid); end
        for (int i = 41; i <= 45; i++) begin
            @(negedge vga_clk);
            if (i == 41) begin
                force_empty = 1'b0;
                clear_underflow = 1'b0;
                checks++;
                if (underflow !== 1'b1) begin errors++; $display("FAIL set_beats_clear: got %b want 1", underflow); end
            end
            if (i == 44) begin
                #1;
                checks++;
                if (vga_rd_valid !== 1'b1) begin errors++; $display("FAIL pop_after_miss: got %b want 1", vga_rd_valid); end
            end
            exp_rgb = (i <= 44) ? 24'hFF00FF : 24'h0A0A0A;
            checks++;
            if ({vga_r, vga_g, vga_b} !== exp_rgb)
                begin errors++; $display("FAIL miss_pixel %0d: got %h want %h", i - 1, {vga_r, vga_g, vga_b}, exp_rgb); end
        end
        wait_cnt(60, 0, to);
        checks++;
        if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_hold: got %b want 1", underflow); end
    endtask

    task automatic test_frame_gating();
        bit to;
        int w, bad_pop, bad_rgb;
        wait_cnt(1, 0, to);
        for (int k = 0; k < 16; k++) begin mem[wr_cnt] = grey_word(8'h40 + k); wr_cnt++; end
        wait_cnt(0, 2, to);
        scan_enable = 1'b1;
        bad_pop = 0; bad_rgb = 0; w = 0;
        do begin
            @(negedge vga_clk);
            w++;
            if ((cyc % FT) != 0) begin
                if (vga_rd_valid !== 1'b0) bad_pop++;
                if ({vga_r, vga_g, vga_b} !== 24'h0) bad_rgb++;
            end
            if ((cyc % FT) == 2 * HT + 6) begin
                checks++;
                if (vga_blank_n !== 1'b1) begin errors++; $display("FAIL gated_blank_n: got %b want 1", vga_blank_n); end
            end
        end while ((cyc % FT) != 0 && w < 2 * FT);
        checks++;
        if (bad_pop !== 0) begin errors++; $display("FAIL gated_pops: got %0d cycles want 0", bad_pop); end
        checks++;
        if (bad_rgb !== 0) begin errors++; $display("FAIL gated_rgb: got %0d cycles want 0", bad_rgb); end
        checks++;
        if (vga_rd_valid !== 1'b1) begin errors++; $display("FAIL gated_first_pop: got %b want 1", vga_rd_valid); end
        @(negedge vga_clk);
        scan_enable = 1'b0;
        checks++;
        if ({vga_r, vga_g, vga_b} !== 24'h404040)
            begin errors++; $display("FAIL gated_first_pixel: got %h want 404040", {vga_r, vga_g, vga_b}); end
    endtask

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    task automatic test_pattern();
        bit to;
        int p0, pops;
        wait_cnt(1, 0, to);
        clear_underflow = 1'b1;
        @(negedge vga_clk);
        clear_underflow = 1'b0;
        for (int k = 0; k < 4; k++) begin mem[wr_cnt] = grey_word(k); wr_cnt++; end
        p0 = rd_ptr;
        pops = 0;
        test_pattern_sel = 1'b1;
        scan_enable = 1'b1;
        wait_cnt(0, 0, to);
        if (vga_rd_valid) pops++;
        for (int i = 1; i <= IW; i++) begin
            @(negedge vga_clk);
            if (i == 1) begin test_pattern_sel = 1'b0; scan_enable = 1'b0; end
            if (vga_rd_valid) pops++;
            if (i == 1) begin
                checks++;
                if ({vga_r, vga_g, vga_b} !== 24'h000000) begin errors++; $display("FAIL bar_px0: got %h want 000000", {vga_r, vga_g, vga_b}); end
            end
            if (i == 9) begin
                checks++;
                if ({vga_r, vga_g, vga_b} !== 24'h0000FF) begin errors++; $display("FAIL bar_px8: got %h want 0000FF", {vga_r, vga_g, vga_b}); end
            end
            if (i == IW) begin
                checks++;
                if ({vga_r, vga_g, vga_b} !== 24'hFFFFFF) begin errors++; $display("FAIL bar_px63: got %h want FFFFFF", {vga_r, vga_g, vga_b}); end
            end
        end
        checks++;
        if (pops !== 0 || rd_ptr !== p0) begin errors++; $display("FAIL pattern_pops: got %0d want 0", pops); end
        checks++;
        if (underflow !== 1'b0) begin errors++; $display("FAIL pattern_underflow: got %b want 0", underflow); end
    endtask
`endif

    initial begin
        vga_reset_n     = 1'b0;
        scan_enable     = 1'b0;
        clear_underflow = 1'b0;
        force_empty     = 1'b0;
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        test_pattern_sel = 1'b0;
`endif
        for (int k = 0; k < 128; k++) mem[k] = '0;
        test_reset();
        test_line_fetch();
        test_unpack_underflow();
        test_frame_gating();
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
